// File: rtl/bcd_counter_pkg.sv
// Shared constants and digit arithmetic for the cascaded modulo counter.
// Digits are always 4 bits wide; the modulus per digit is a parameter (2..16).
package bcd_counter_pkg;

    localparam int DIGIT_W = 4;

    // Largest legal digit value for a given modulus.
    function automatic logic [DIGIT_W-1:0] digit_max(input int radix);
        return DIGIT_W'(radix - 1);
    endfunction

    // One up or down step with wrap. Out-of-range inputs fold to a legal value
    // so a digit can never leave 0..radix-1 even if upset.
    function automatic logic [DIGIT_W-1:0] digit_next(
        input logic [DIGIT_W-1:0] value,
        input logic               up,
        input int                 radix
    );
        logic [DIGIT_W-1:0] max_v;
        max_v = digit_max(radix);
        if (up) begin
            return (value >= max_v) ? '0 : value + DIGIT_W'(1);
        end
        return ((value == '0) || (value > max_v)) ? max_v : value - DIGIT_W'(1);
    endfunction

    function automatic logic [DIGIT_W-1:0] clamp_digit(
        input logic [DIGIT_W-1:0] value,
        input int                 radix
    );
        logic [DIGIT_W-1:0] max_v;
        max_v = digit_max(radix);
        return (value > max_v) ? max_v : value;
    endfunction

endpackage

// File: rtl/bcd_counter_chain_digit.sv
// One 4-bit modulo-RADIX digit: clear, clamped load, and a single up/down step
// when step_en is high. tc flags the terminal value for the current direction.
module bcd_digit
    import bcd_counter_pkg::*;
#(
    parameter int RADIX = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step_en,
    input  logic               up_dn,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_nibble,
    output logic [DIGIT_W-1:0] value,
    output logic               tc
);

    localparam logic [DIGIT_W-1:0] MAX_V = digit_max(RADIX);

    logic [DIGIT_W-1:0] r_value;
    logic [DIGIT_W-1:0] w_terminal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= clamp_digit(load_nibble, RADIX);
        end else if (step_en) begin
            r_value <= digit_next(r_value, up_dn, RADIX);
        end
    end

    assign w_terminal = up_dn ? MAX_V : '0;
    assign value      = r_value;
    assign tc         = (r_value == w_terminal);

endmodule

// File: rtl/bcd_counter_chain.sv
// Multi-digit modulo counter with up/down, clear, load and a zero-latency chain
// carry. Define BCD_COUNTER_SAT_EN to saturate at the limit instead of wrapping.
module bcd_counter_chain
    import bcd_counter_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int RADIX  = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      up_dn,
    input  logic                      clr,
    input  logic                      load,
    input  logic [DIGIT_W*DIGITS-1:0] load_val,
    output logic [DIGIT_W*DIGITS-1:0] cnt,
    output logic [DIGITS-1:0]         digit_tc,
    output logic                      carry_out
);

    // w_chain[k] is high when en is high and every digit below k is terminal,
    // i.e. digit k is due to step this cycle.
    logic [DIGITS:0]   w_chain;
    logic [DIGITS-1:0] w_tc;
    logic [DIGITS-1:0] w_step;

    assign w_chain[0] = en;

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_digit
            assign w_chain[k+1] = w_chain[k] & w_tc[k];

            bcd_digit #(
                .RADIX(RADIX)
            ) u_digit (
                .clk        (clk),
                .rst_n      (rst_n),
                .step_en    (w_step[k]),
                .up_dn      (up_dn),
                .clr        (clr),
                .load       (load),
                .load_nibble(load_val[DIGIT_W*k +: DIGIT_W]),
                .value      (cnt[DIGIT_W*k +: DIGIT_W]),
                .tc         (w_tc[k])
            );
        end
    endgenerate

`ifdef BCD_COUNTER_SAT_EN
    // At the limit every digit is terminal; freeze the whole chain there.
    logic w_all_tc;
    assign w_all_tc = &w_tc;
    assign w_step   = w_chain[DIGITS-1:0] & {DIGITS{~w_all_tc}};
`else
    assign w_step   = w_chain[DIGITS-1:0];
`endif

    assign digit_tc  = w_tc;
    assign carry_out = w_chain[DIGITS] & ~clr & ~load;

endmodule

// File: doc/bcd_counter_chain.md
Name: bcd_counter_chain

Overview:
- Parametrised multi-digit modulo counter; successor to the single-digit decade counter.
- DIGITS cascaded digits, each modulo RADIX (default 10 = BCD).
- Adds up/down counting, synchronous clear and load, per-digit terminal-count flags, and a chain carry for cascading instances.
- Used as an event/time counter feeding display and timer blocks.

Parameters:
- DIGITS, 4, number of cascaded digits (1..8).
- RADIX, 10, modulus of each digit (2..16); digit width is fixed at 4 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; the chain advances one step per clk while high.
- up_dn  input  1  1 = count up, 0 = count down.
- clr  input  1  synchronous clear to zero.
- load  input  1  synchronous parallel load.
- load_val  input  4*DIGITS  load value; digit k is in bits [4k+3:4k].
- cnt  output  4*DIGITS  current count; digit 0 is least significant.
- digit_tc  output  DIGITS  per-digit terminal flag, combinational.
- carry_out  output  1  chain carry/borrow, combinational.

Behaviour:
- Reset: rst_n low forces cnt=0 immediately, regardless of clk.
  - Outputs then read digit_tc = all 0 when up_dn=1, and carry_out=0.
  - Deassertion is synchronised by the integrator; the block samples inputs from the first clk edge after release.
- Priority at each rising edge: clr > load > en. Otherwise cnt holds.
- clr: cnt <= 0, regardless of en and up_dn.
- load: each digit takes its load_val nibble.
  - A nibble >= RADIX is clamped to RADIX-1.
  - No carry is produced on the load cycle.
- Terminal value of a digit: RADIX-1 when up_dn=1; 0 when up_dn=0.
  - digit_tc[k] = (digit k == terminal value).
- Step rule (en=1, no clr/load):
  - Digit 0 always steps.
  - Digit k>0 steps when en and digit_tc[0..k-1] are all 1.
  - Up step: RADIX-1 -> 0, otherwise +1. Down step: 0 -> RADIX-1, otherwise -1.
- carry_out = en & (&digit_tc) & ~clr & ~load.
  - Same cycle as the wrap edge; zero latency.
  - Meant to drive the en of the next cascaded instance.
- Wrap-around:
  - Up, all digits RADIX-1: next cnt=0, carry_out=1 during that cycle.
  - Down, all digits 0: next cnt = all RADIX-1, carry_out=1.
- up_dn may change on any cycle. It takes effect on the next edge; no state is retained about direction.
- cnt digits never hold a value >= RADIX under any input sequence.
- Reset asserted mid-count: cnt=0 at once; any pending load or clr is discarded.

Optional Feature:
- Macro: BCD_COUNTER_SAT_EN.
- Defined: the counter saturates instead of wrapping.
  - At all RADIX-1 counting up, or all 0 counting down, cnt holds.
  - carry_out still pulses for each cycle en is high at the limit (overflow indication).
  - clr and load behave as normal.
- Undefined: wrap-around as specified above. No extra logic is built.

Decomposition:
- Package bcd_counter_pkg holds:
  - DIGIT_W = 4.
  - Function digit_next(value, up, radix).
  - Function clamp_digit(value, radix).
- Sub-module bcd_digit: one 4-bit digit.
  - Inputs: clk, rst_n, step_en, up_dn, clr, load, load_nibble.
  - Outputs: value, tc.
- The top module instantiates DIGITS copies via generate and builds the tc-AND enable chain.

Test Plan (DIGITS=2, RADIX=10 unless stated):
- Reset: rst_n=0 mid-count at cnt=0x37 -> cnt=0x00 before the next edge; carry_out=0.
- Up wrap: load 0x98, en=1, up_dn=1 -> 0x99 then 0x00. carry_out=1 only in the cycle cnt=0x99.
- Down borrow: load 0x10, up_dn=0 -> 0x09. load 0x00 -> 0x99 with carry_out=1 during the 0x00 cycle.
- Priority and clamp:
  - clr=1, load=1, en=1 at cnt=0x45 -> 0x00.
  - load 0xFA -> 0x99.
  - en=0 for 5 clocks -> cnt holds.
- Cascade: chain two instances (carry_out -> en), count up from reset for 10000 clocks -> combined 0x0000 with upper carry_out pulse at clock 9999.
- BCD_COUNTER_SAT_EN: load 0x99, up, en=1 for 3 clocks -> cnt stays 0x99, carry_out=1 each cycle. With RADIX=16, load 0x00, down -> holds at 0x00.
